// File: rtl/seg7_digits_ctrl_if.sv
// Avalon-MM slave bus for the 7-segment digit controller; readdata is registered in the slave.
interface seg7_digits_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, read_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/seg7_digits_ctrl.sv
// Memory-mapped hex driver for up to 8 seven-segment digits with optional per-digit blink.
// Blink counter, PERIOD, blink mask and STATUS exist only when SEG7_DIGITS_BLINK_EN is defined.
module seg7_digits_ctrl #(
  parameter int DIGITS     = 6,
  parameter int ACTIVE_LOW = 1,
  parameter int PERIOD_W   = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_digits_ctrl_if.slave     bus,
  output logic [DIGITS*7-1:0]   out_port
);

  localparam logic [7:0]  DMASK    = 8'((9'd1 << DIGITS) - 9'd1);
  localparam logic [31:0] VMASK    = 32'((33'd1 << (4 * DIGITS)) - 33'd1);
`ifdef SEG7_DIGITS_BLINK_EN
  localparam logic [16:0] CMASK    = {1'b1, DMASK, DMASK};
`else
  localparam logic [16:0] CMASK    = {1'b1, 8'h00, DMASK};
`endif
  localparam logic [6:0]  ZERO_SEG = (ACTIVE_LOW != 0) ? 7'h40 : 7'h3F;

  logic [31:0]         value;
  logic [16:0]         ctrl;
  logic [31:0]         readdata_q;
  logic [31:0]         rdata;
  logic [31:0]         period_word;
  logic [31:0]         status_word;
  logic [DIGITS*7-1:0] seg_next;
  logic                wr;
  logic                rd;
  logic                phase;

  assign wr = bus.chipselect & ~bus.write_n;
  assign rd = bus.chipselect & ~bus.read_n;
  assign bus.readdata = readdata_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] n, input logic lit);
    logic [6:0] seg;
    seg = lit ? hex7(n) : 7'h00;
    return (ACTIVE_LOW != 0) ? ~seg : seg;
  endfunction

`ifdef SEG7_DIGITS_BLINK_EN
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] count;
  logic                period_wr;

  assign period_wr = wr && (bus.address == 3'd2);

  // A PERIOD write restarts from 0, so a shortened period never runs through 2^PERIOD_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period <= '0;
      count  <= '0;
      phase  <= 1'b1;
    end else if (period_wr) begin
      period <= bus.writedata[PERIOD_W-1:0];
      count  <= '0;
      phase  <= 1'b1;
    end else if (period == '0) begin
      count  <= '0;
      phase  <= 1'b1;
    end else if (count >= period - 1'b1) begin
      count  <= '0;
      phase  <= ~phase;
    end else begin
      count  <= count + 1'b1;
    end
  end

  assign period_word = 32'(period);
  assign status_word = 32'({count, 7'b0, phase});
`else
  assign phase       = 1'b1;
  assign period_word = '0;
  assign status_word = '0;
`endif

  always_comb begin
    rdata = '0;
    case (bus.address)
      3'd0:    rdata = value;
      3'd1:    rdata = 32'(ctrl);
      3'd2:    rdata = period_word;
      3'd3:    rdata = status_word;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    seg_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_next[7*i +: 7] = digit_seg(value[4*i +: 4],
                                     ctrl[i] & ~ctrl[16] & ~(ctrl[8+i] & ~phase));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value      <= '0;
      ctrl       <= {9'h000, DMASK};
      readdata_q <= '0;
      out_port   <= {DIGITS{ZERO_SEG}};
    end else begin
      if (wr) begin
        case (bus.address)
          3'd0:    value <= bus.writedata & VMASK;
          3'd1:    ctrl  <= bus.writedata[16:0] & CMASK;
          3'd4:    ctrl  <= (ctrl | bus.writedata[16:0]) & CMASK;
          3'd5:    ctrl  <= ctrl & ~bus.writedata[16:0];
          default: ;
        endcase
      end
      if (rd) readdata_q <= rdata;
      out_port <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_digits_ctrl.sv
// Directed bench for seg7_digits_ctrl (DIGITS=6, ACTIVE_LOW=1); expectations queued at drive time, checked at output.
module tb_seg7_digits_ctrl;

  localparam int DIGITS = 6;
  localparam logic [34:0] UPPER = {7'h40, 7'h40, 7'h08, 7'h12, 7'h0E};
`ifdef SEG7_DIGITS_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic                clk;
  logic                reset;
  logic [DIGITS*7-1:0] out_port;
  int                  compared = 0;
  int                  mismatched = 0;
  logic [63:0]         exp_q[$];
  string               tag_q[$];

  seg7_digits_ctrl_if bus ();

  seg7_digits_ctrl #(.DIGITS(DIGITS), .ACTIVE_LOW(1), .PERIOD_W(24)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t, input logic [63:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic check_out(input string t, input logic [41:0] e);
    push(t, {22'b0, e});
    check({22'b0, out_port});
  endtask

  // Called at a negedge; the access is taken on the following posedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string t);
    push(t, {32'b0, e});
    bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
    check({32'b0, bus.readdata});
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1;
    bus.writedata = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_out("out_reset", {6{7'h40}});
    push("rd_reset", 64'h0);
    check({32'b0, bus.readdata});
    reset = 1'b0;
    @(negedge clk);

    rd(3'd1, 32'h3F, "ctrl_reset");
    rd(3'd0, 32'h0, "value_reset");
    rd(3'd2, 32'h0, "period_reset");
    rd(3'd3, BLINK ? 32'h1 : 32'h0, "status_reset");

    wr(3'd0, 32'h00A5F3);
    check_out("out_latency", {6{7'h40}});
    @(negedge clk);
    check_out("out_a5f3", {UPPER, 7'h30});
    rd(3'd0, 32'h00A5F3, "value_rd");

    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, 32'h00FF_FFFF, "value_mask");
    check_out("out_all_f", {6{7'h0E}});
    wr(3'd0, 32'h00A5F3);

    wr(3'd1, 32'h0001_FFFF);
    rd(3'd1, BLINK ? 32'h13F3F : 32'h1003F, "ctrl_mask");
    check_out("out_gblank", {6{7'h7F}});
    wr(3'd1, 32'h05);
    @(negedge clk);
    check_out("out_enable", {7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h7F, 7'h30});
    wr(3'd1, 32'h3F);

`ifdef SEG7_DIGITS_BLINK_EN
    wr(3'd4, 32'h100);
    wr(3'd2, 32'd4);
    for (int k = 0; k < 10; k++) begin
      logic ph;
      ph = ((k / 4) % 2) == 0;
      rd(3'd3, {8'b0, 24'(k % 4), 7'b0, ph}, "status_blink");
      check_out("out_blink", {UPPER, ph ? 7'h30 : 7'h7F});
    end
    wr(3'd2, 32'd8);
    repeat (6) @(negedge clk);
    wr(3'd2, 32'd2);
    rd(3'd3, 32'h001, "status_shrink0");
    rd(3'd3, 32'h101, "status_shrink1");
    rd(3'd3, 32'h000, "status_shrink2");
    rd(3'd3, 32'h100, "status_shrink3");
    rd(3'd2, 32'd2, "period_rd");
    wr(3'd2, 32'd0);
    rd(3'd3, 32'h001, "status_period0");
`else
    wr(3'd4, 32'h100);
    rd(3'd1, 32'h3F, "ctrl_no_blink");
    wr(3'd2, 32'd4);
    rd(3'd2, 32'h0, "period_ignored");
    rd(3'd3, 32'h0, "status_absent");
    check_out("out_steady", {UPPER, 7'h30});
`endif

    wr(3'd4, 32'h10000);
    @(negedge clk);
    check_out("out_or_blank", {6{7'h7F}});
    wr(3'd5, 32'h10000);
    rd(3'd1, BLINK ? 32'h13F : 32'h3F, "ctrl_or_clr");
    check_out("out_restored", {UPPER, 7'h30});

    rd(3'd0, 32'h00A5F3, "value_rd2");
    repeat (2) @(negedge clk);
    push("rd_hold", {32'b0, 32'h00A5F3});
    check({32'b0, bus.readdata});
    rd(3'd6, 32'h0, "rd_addr6");
    wr(3'd3, 32'hFFFF_FFFF);
    rd(3'd3, BLINK ? 32'h1 : 32'h0, "status_wr_ignored");
    rd(3'd4, 32'h0, "rd_addr4");
    rd(3'd1, BLINK ? 32'h13F : 32'h3F, "ctrl_rd3");
    rd(3'd5, 32'h0, "rd_addr5");
    rd(3'd7, 32'h0, "rd_addr7");
    wr(3'd6, 32'h0);
    wr(3'd7, 32'h0);
    rd(3'd0, 32'h00A5F3, "value_after_wr67");

    wr(3'd2, 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_out("out_in_reset", {6{7'h40}});
    push("rd_in_reset", 64'h0);
    check({32'b0, bus.readdata});
    reset = 1'b0;
    rd(3'd3, BLINK ? 32'h1 : 32'h0, "status_after_reset");
    rd(3'd2, 32'h0, "period_after_reset");
    rd(3'd1, 32'h3F, "ctrl_after_reset");
    rd(3'd0, 32'h0, "value_after_reset");

    if (exp_q.size() != 0) begin
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
